// File: rtl/ring_counter_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_counter_param_if: control/status bundle for ring_counter_param      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface ring_counter_param_if #(
  parameter int N = 16
) ();
  localparam int IW = $clog2(2 * N);

  logic          en;
  logic          dir;
  logic          load;
  logic [IW-1:0] load_idx;
  logic [N-1:0]  r_out;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          err;

  modport master (
    output en, dir, load, load_idx,
    input  r_out, idx, wrap, err
  );

  modport slave (
    input  en, dir, load, load_idx,
    output r_out, idx, wrap, err
  );
endinterface
`default_nettype wire

// File: rtl/ring_counter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_counter_param: registered ring/Johnson position generator           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ring_counter_param #(
  parameter int N       = 16,
  parameter int JOHNSON = 0,
  parameter int START   = 0
) (
  input  wire logic             clk,
  input  wire logic             nRST,
  ring_counter_param_if.slave   bus
);
  localparam int            IW      = $clog2(2 * N);
  localparam int            L       = (JOHNSON != 0) ? 2 * N : N;
  localparam logic [IW:0]   C_L     = (IW+1)'(L);
  localparam logic [IW:0]   C_N     = (IW+1)'(N);
  localparam logic [IW-1:0] C_LAST  = IW'(L - 1);
  localparam logic [IW-1:0] C_START = IW'(START);

  // Positions 0..N fill from bit 0; positions above N drain from bit 0.
  function automatic logic [N-1:0] decode(input logic [IW-1:0] k);
    logic [N-1:0] v;
    logic [IW:0]  kk;
    v  = '0;
    kk = {1'b0, k};
    for (int i = 0; i < N; i++) begin
      if (JOHNSON == 0)
        v[i] = ((IW+1)'(i) == kk);
      else if (kk <= C_N)
        v[i] = ((IW+1)'(i) < kk);
      else
        v[i] = ((IW+1)'(i) >= (kk - C_N));
    end
    return v;
  endfunction

  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_pattern;
  logic          r_wrap;
  logic          r_err;

  logic [IW-1:0] w_next_idx;
  logic          w_wrap;
  logic          w_err;
  logic          w_load_ok;

  assign w_load_ok = ({1'b0, bus.load_idx} < C_L);

  always_comb begin
    w_next_idx = r_idx;
    w_wrap     = 1'b0;
    w_err      = 1'b0;
    if (bus.load) begin
      if (w_load_ok)
        w_next_idx = bus.load_idx;
      else
        w_err = 1'b1;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (r_idx == C_LAST) begin
          w_next_idx = '0;
          w_wrap     = 1'b1;
        end else begin
          w_next_idx = r_idx + IW'(1);
        end
      end else begin
        if (r_idx == '0) begin
          w_next_idx = C_LAST;
          w_wrap     = 1'b1;
        end else begin
          w_next_idx = r_idx - IW'(1);
        end
      end
    end
  end

  // Pattern is decoded from the next index so it lands on the same edge as idx.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_idx     <= C_START;
      r_pattern <= decode(C_START);
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_idx     <= w_next_idx;
      r_pattern <= decode(w_next_idx);
      r_wrap    <= w_wrap;
      r_err     <= w_err;
    end
  end

  assign bus.idx   = r_idx;
  assign bus.r_out = r_pattern;
  assign bus.wrap  = r_wrap;
  assign bus.err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ring_counter_param.sv
`default_nettype none
// Scoreboard bench: a 16-bit one-hot ring and a 4-bit Johnson ring driven
// with the same control stream, checked against an arithmetic position model.
module tb_ring_counter_param;
  logic clk;
  logic nRST;

  ring_counter_param_if #(.N(16)) b16 ();
  ring_counter_param_if #(.N(4))  b4 ();

  ring_counter_param #(.N(16), .JOHNSON(0), .START(0)) dut16 (
    .clk (clk),
    .nRST(nRST),
    .bus (b16)
  );

  ring_counter_param #(.N(4), .JOHNSON(1), .START(0)) dut4 (
    .clk (clk),
    .nRST(nRST),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o16;
    int          i16;
    bit          w16;
    bit          e16;
    logic [3:0]  o4;
    int          i4;
    bit          w4;
    bit          e4;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   p16    = 0;
  int   p4     = 0;

  function automatic logic [15:0] dec(input int n, input bit johnson, input int k);
    int r;
    if (!johnson)
      r = 1 << k;
    else if (k <= n)
      r = (1 << k) - 1;
    else
      r = ((1 << n) - 1) ^ ((1 << (k - n)) - 1);
    return 16'(r);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic advance(input int len, input bit e, input bit d, input bit l,
                         input int li, inout int pos, output bit wr, output bit er);
    wr = 1'b0;
    er = 1'b0;
    if (l) begin
      if (li < len) pos = li;
      else er = 1'b1;
    end else if (e) begin
      if (!d) begin
        wr  = (pos == len - 1);
        pos = (pos + 1) % len;
      end else begin
        wr  = (pos == 0);
        pos = (pos + len - 1) % len;
      end
    end
  endtask

  task automatic drive(input bit e, input bit d, input bit l, input int li16, input int li4);
    b16.en = e;  b16.dir = d;  b16.load = l;  b16.load_idx = 5'(li16);
    b4.en  = e;  b4.dir  = d;  b4.load  = l;  b4.load_idx  = 3'(li4);
  endtask

  task automatic step(input bit e, input bit d, input bit l, input int li16, input int li4);
    exp_t x;
    bit   wr, er;
    @(negedge clk);
    drive(e, d, l, li16, li4);
    advance(16, e, d, l, li16, p16, wr, er);
    x.o16 = dec(16, 1'b0, p16); x.i16 = p16; x.w16 = wr; x.e16 = er;
    advance(8, e, d, l, li4, p4, wr, er);
    x.o4 = 4'(dec(4, 1'b1, p4)); x.i4 = p4; x.w4 = wr; x.e4 = er;
    q.push_back(x);
  endtask

  task automatic reset_check();
    check("rst_out16",  b16.r_out, 32'h1);
    check("rst_idx16",  b16.idx,   0);
    check("rst_wrap16", b16.wrap,  0);
    check("rst_err16",  b16.err,   0);
    check("rst_out4",   b4.r_out,  0);
    check("rst_idx4",   b4.idx,    0);
  endtask

  // Reset lands between edges; outputs must respond without a clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    drive(0, 0, 0, 0, 0);
    nRST = 1'b0;
    #1;
    reset_check();
    p16 = 0;
    p4  = 0;
    @(negedge clk);
    nRST = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("out16",  b16.r_out, x.o16);
        check("idx16",  b16.idx,   x.i16);
        check("wrap16", b16.wrap,  x.w16);
        check("err16",  b16.err,   x.e16);
        check("out4",   b4.r_out,  x.o4);
        check("idx4",   b4.idx,    x.i4);
        check("wrap4",  b4.wrap,   x.w4);
        check("err4",   b4.err,    x.e4);
      end
    end
  end

  initial begin : stimulus
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset_check();
    nRST = 1'b1;

    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    async_reset();

    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    step(1, 0, 1, 5, 3);
    step(0, 0, 1, 20, 2);
    step(1, 1, 1, 31, 7);

    for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)), 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 31), $urandom_range(0, 7));

    async_reset();
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 31), $urandom_range(0, 7));

    @(posedge clk);
    #2;
    check("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
